// File: rtl/ram_write_sequencer.sv
// Drains burst address/data CDC FIFOs into the DDR3 MIG app/wdf write ports:
// one write command plus two wdf beats per burst, with a running burst counter.
module ram_write_sequencer #(
    parameter int ADDR_WIDTH = 29,
    parameter int DATA_WIDTH = 256
) (
    input  logic                    clk_ram,
    input  logic                    rst,
    output logic                    addr_fifo_rd_en,
    input  logic [ADDR_WIDTH-1:0]   addr_fifo_rd_data,
    input  logic [7:0]              addr_fifo_rd_size,
    output logic                    data_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   data_fifo_rd_data,
    input  logic [9:0]              data_fifo_rd_size,
    output logic                    app_en,
    output logic [2:0]              app_cmd,
    output logic [ADDR_WIDTH-1:0]   app_addr,
    input  logic                    app_rdy,
    output logic                    app_wdf_wren,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                    app_wdf_end,
    input  logic                    app_wdf_rdy,
    output logic [31:0]             burst_count,
    output logic                    busy,
    output logic [1:0]              state_dbg
);

    // Handshake: app_en/app_wdf_wren are valids that hold with stable payload until
    // the matching rdy is seen high in the same cycle; a transfer happens on valid&&rdy.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD0 = 2'd1,
        LOAD1 = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] beat0_q;
    logic [DATA_WIDTH-1:0] beat1_q;
    logic                  cmd_done;
    logic                  beat_idx;

    logic start_ok;
    logic cmd_acc;
    logic cmd_fin;
    logic wdf_acc;
    logic beats_fin;
    logic issue_exit;
    logic pop_both;

    assign start_ok   = (addr_fifo_rd_size != 8'd0) && (data_fifo_rd_size >= 10'd2);
    assign cmd_acc    = app_en && app_rdy;
    assign cmd_fin    = cmd_done || cmd_acc;
    assign wdf_acc    = app_wdf_wren && app_wdf_rdy;
    // beat1 is either being accepted now or was accepted earlier (wren already dropped)
    assign beats_fin  = beat_idx && (!app_wdf_wren || app_wdf_rdy);
    assign issue_exit = (state == ISSUE) && cmd_fin && beats_fin;

    // Pops are decoded from state so the next burst's LOAD0 follows the exit cycle directly.
    assign pop_both        = !rst && start_ok && ((state == IDLE) || issue_exit);
    assign addr_fifo_rd_en = pop_both;
    assign data_fifo_rd_en = pop_both || (!rst && (state == LOAD0));

    assign app_cmd      = 3'b000;
    assign app_wdf_mask = '0;
    assign busy         = (state != IDLE);
    assign state_dbg    = state;

    always_ff @(posedge clk_ram) begin
        if (rst) begin
            state        <= IDLE;
            beat0_q      <= '0;
            beat1_q      <= '0;
            cmd_done     <= 1'b0;
            beat_idx     <= 1'b0;
            app_en       <= 1'b0;
            app_addr     <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_end  <= 1'b0;
            burst_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) state <= LOAD0;
                end
                LOAD0: begin
                    app_addr <= addr_fifo_rd_data;
                    beat0_q  <= data_fifo_rd_data;
                    state    <= LOAD1;
                end
                LOAD1: begin
                    beat1_q      <= data_fifo_rd_data;
                    cmd_done     <= 1'b0;
                    beat_idx     <= 1'b0;
                    app_en       <= 1'b1;
                    app_wdf_wren <= 1'b1;
                    app_wdf_data <= beat0_q;
                    app_wdf_end  <= 1'b0;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    if (cmd_acc) begin
                        app_en   <= 1'b0;
                        cmd_done <= 1'b1;
                    end
                    if (wdf_acc) begin
                        if (!beat_idx) begin
                            beat_idx     <= 1'b1;
                            app_wdf_data <= beat1_q;
                            app_wdf_end  <= 1'b1;
                        end else begin
                            app_wdf_wren <= 1'b0;
                            app_wdf_end  <= 1'b0;
                        end
                    end
                    if (issue_exit) begin
                        burst_count <= burst_count + 32'd1;
                        state       <= start_ok ? LOAD0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_write_sequencer.sv
// Scoreboard bench for ram_write_sequencer: bench-side FIFO model feeds bursts,
// a negedge monitor compares MIG command/beat transfers against expected queues.
module tb_ram_write_sequencer;

    localparam int AW = 29;
    localparam int DW = 256;

    // clock / reset
    logic clk_ram = 1'b0;
    always #3 clk_ram = ~clk_ram;
    logic rst;

    logic          addr_fifo_rd_en;
    logic [AW-1:0] addr_fifo_rd_data;
    logic [7:0]    addr_fifo_rd_size;
    logic          data_fifo_rd_en;
    logic [DW-1:0] data_fifo_rd_data;
    logic [9:0]    data_fifo_rd_size;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_rdy;
    logic          app_wdf_wren;
    logic [DW-1:0] app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic [31:0]   burst_count;
    logic          busy;
    logic [1:0]    state_dbg;

    ram_write_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_ram(clk_ram), .rst(rst),
        .addr_fifo_rd_en(addr_fifo_rd_en), .addr_fifo_rd_data(addr_fifo_rd_data),
        .addr_fifo_rd_size(addr_fifo_rd_size),
        .data_fifo_rd_en(data_fifo_rd_en), .data_fifo_rd_data(data_fifo_rd_data),
        .data_fifo_rd_size(data_fifo_rd_size),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .burst_count(burst_count), .busy(busy), .state_dbg(state_dbg)
    );

    // scoreboard state
    logic [AW-1:0] fa[$];
    logic [DW-1:0] fd[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW:0]   exp_beat_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int en_cycles = 0;
    int acc_cyc[$];
    int app_rdy_mode = 0;
    int wdf_rdy_mode = 0;

    task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] r;
        r = AW'($urandom);
        return (r & 29'h0FFF_FFFC) | 29'h1000_0000;
    endfunction

    // driver tasks
    task automatic upd_sizes();
        addr_fifo_rd_size = 8'(fa.size());
        data_fifo_rd_size = 10'(fd.size());
    endtask

    task automatic push_addr(input logic [AW-1:0] a);
        fa.push_back(a);
        exp_addr_q.push_back(a);
        upd_sizes();
    endtask

    task automatic push_data(input logic [DW-1:0] d, input logic last);
        fd.push_back(d);
        exp_beat_q.push_back({last, d});
        upd_sizes();
    endtask

    task automatic push_burst(input logic [AW-1:0] a);
        push_addr(a);
        push_data(rand_word(), 1'b0);
        push_data(rand_word(), 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || fa.size() != 0 || exp_addr_q.size() != 0 || exp_beat_q.size() != 0)
               && n < budget) begin
            @(negedge clk_ram);
            n++;
        end
        check("idle_timeout", n >= budget, 0);
    endtask

    // FIFO model: a pop seen this cycle presents the next word after the edge
    initial begin
        logic pa, pd;
        addr_fifo_rd_data = '0;
        data_fifo_rd_data = '0;
        forever begin
            @(negedge clk_ram);
            pa = addr_fifo_rd_en;
            pd = data_fifo_rd_en;
            @(posedge clk_ram);
            #1;
            if (pa) begin
                if (fa.size() == 0) check("addr_underflow", 1, 0);
                else addr_fifo_rd_data = fa.pop_front();
            end
            if (pd) begin
                if (fd.size() == 0) check("data_underflow", 1, 0);
                else data_fifo_rd_data = fd.pop_front();
            end
            upd_sizes();
        end
    end

    // ready driver: 0 = always ready, 1 = random, 2 = held low
    initial begin
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        forever begin
            @(posedge clk_ram);
            #1;
            app_rdy     = (app_rdy_mode == 0) ? 1'b1 :
                          (app_rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            app_wdf_rdy = (wdf_rdy_mode == 0) ? 1'b1 :
                          (wdf_rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // monitor
    logic          prev_rst = 1'b1;
    logic          prev_en_wait = 1'b0;
    logic          prev_wdf_wait = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_end = 1'b0;

    always @(negedge clk_ram) begin
        cyc++;
        if (!rst) begin
            if (addr_fifo_rd_en) pop_cnt++;
            if (app_en) en_cycles++;
            check("end_without_wren", app_wdf_end & ~app_wdf_wren, 0);
            if (app_en) check("app_cmd", app_cmd, 0);
            if (app_wdf_wren) check("app_wdf_mask", app_wdf_mask, 0);
            if (!prev_rst && prev_en_wait) begin
                check("app_en_held", app_en, 1);
                check("app_addr_held", app_addr, prev_addr);
            end
            if (!prev_rst && prev_wdf_wait) begin
                check("wren_held", app_wdf_wren, 1);
                check("wdf_data_held", app_wdf_data, prev_data);
                check("wdf_end_held", app_wdf_end, prev_end);
            end
            if (app_en && app_rdy) begin
                acc_cyc.push_back(cyc);
                if (exp_addr_q.size() == 0) check("unexpected_cmd", 1, 0);
                else check("app_addr", app_addr, exp_addr_q.pop_front());
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                if (exp_beat_q.size() == 0) check("unexpected_beat", 1, 0);
                else check("wdf_beat", {app_wdf_end, app_wdf_data}, exp_beat_q.pop_front());
            end
        end
        prev_rst      = rst;
        prev_en_wait  = app_en && !app_rdy;
        prev_addr     = app_addr;
        prev_wdf_wait = app_wdf_wren && !app_wdf_rdy;
        prev_data     = app_wdf_data;
        prev_end      = app_wdf_end;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a;
        int n;
        rst = 1'b1;
        addr_fifo_rd_size = '0;
        data_fifo_rd_size = '0;
        repeat (3) @(posedge clk_ram);
        #1 rst = 1'b0;

        // reset state and idle with empty FIFOs
        @(negedge clk_ram);
        check("rst_addr_rd_en", addr_fifo_rd_en, 0);
        check("rst_data_rd_en", data_fifo_rd_en, 0);
        check("rst_app_en", app_en, 0);
        check("rst_wren", app_wdf_wren, 0);
        check("rst_wdf_end", app_wdf_end, 0);
        check("rst_app_addr", app_addr, 0);
        check("rst_wdf_data", app_wdf_data, 0);
        check("rst_busy", busy, 0);
        check("rst_burst_count", burst_count, 0);
        pop_cnt = 0;
        repeat (100) @(negedge clk_ram);
        check("idle_pops", pop_cnt, 0);
        check("idle_burst_count", burst_count, 0);

        // single burst, always ready
        en_cycles = 0;
        @(posedge clk_ram);
        #1 push_burst(29'h1000_0004);
        wait_idle(50);
        check("single_en_cycles", en_cycles, 1);
        check("single_burst_count", burst_count, 1);
        check("single_busy", busy, 0);

        // one data word short: no pop until the second word arrives
        @(posedge clk_ram);
        #1;
        pop_cnt = 0;
        push_addr(rand_addr());
        push_data(rand_word(), 1'b0);
        repeat (5) @(negedge clk_ram);
        check("short_no_pop", pop_cnt, 0);
        check("short_busy", busy, 0);
        @(posedge clk_ram);
        #1 push_data(rand_word(), 1'b1);
        @(negedge clk_ram);
        check("start_rd_en", addr_fifo_rd_en, 1);
        wait_idle(50);
        check("short_burst_count", burst_count, 2);

        // command held back by app_rdy while both beats complete
        app_rdy_mode = 2;
        @(posedge clk_ram);
        @(posedge clk_ram);
        #1 push_burst(rand_addr());
        repeat (12) @(negedge clk_ram);
        check("cmd_wait_busy", busy, 1);
        check("cmd_wait_en", app_en, 1);
        check("cmd_wait_beats_left", exp_beat_q.size(), 0);
        check("cmd_wait_addr_left", exp_addr_q.size(), 1);
        app_rdy_mode = 0;
        wait_idle(50);
        check("cmd_wait_burst_count", burst_count, 3);

        // eight queued bursts with random ready on both ports
        app_rdy_mode = 1;
        wdf_rdy_mode = 1;
        @(posedge clk_ram);
        #1;
        for (int i = 0; i < 8; i++) push_burst(rand_addr());
        wait_idle(800);
        check("random_burst_count", burst_count, 11);

        // back-to-back spacing when always ready
        app_rdy_mode = 0;
        wdf_rdy_mode = 0;
        @(posedge clk_ram);
        @(negedge clk_ram);
        acc_cyc.delete();
        @(posedge clk_ram);
        #1;
        for (int i = 0; i < 4; i++) push_burst(rand_addr());
        wait_idle(100);
        check("spacing_cmd_count", acc_cyc.size(), 4);
        if (acc_cyc.size() == 4)
            for (int i = 1; i < 4; i++) check("burst_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
        check("spacing_burst_count", burst_count, 15);

        // reset in ISSUE after beat0 accepted
        app_rdy_mode = 2;
        @(posedge clk_ram);
        @(posedge clk_ram);
        #1 push_burst(rand_addr());
        n = 0;
        @(negedge clk_ram);
        while (!app_wdf_end && n < 50) begin
            @(negedge clk_ram);
            n++;
        end
        check("reached_beat1", app_wdf_end, 1);
        @(posedge clk_ram);
        #1 rst = 1'b1;
        @(posedge clk_ram);
        #1 rst = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        @(negedge clk_ram);
        check("midrst_app_en", app_en, 0);
        check("midrst_wren", app_wdf_wren, 0);
        check("midrst_wdf_end", app_wdf_end, 0);
        check("midrst_busy", busy, 0);
        check("midrst_state", state_dbg, 0);
        check("midrst_burst_count", burst_count, 0);
        app_rdy_mode = 0;
        @(posedge clk_ram);
        @(posedge clk_ram);
        a = 29'h1ABC_DEF0;
        #1 push_burst(a);
        wait_idle(50);
        check("post_rst_burst_count", burst_count, 1);
        check("post_rst_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
